inverse_quantiser: RTL
======================

Name: inverse_quantiser

Overview:
- Arithmetic stage directly downstream of the intra and non-intra quantiser matrix stores.
- Takes the inverse-scanned 64-coefficient stream of each block, one coefficient per enabled cycle, and drives the shared matrix read address.
- Selects the intra or non-intra weight, applies quantiser_scale, saturation and mismatch control (ISO/IEC 13818-2 par. 7.4).
- Emits reconstructed DCT coefficients to the IDCT.

Parameters:
None; all widths are fixed by ISO/IEC 13818-2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active low
clk_en  in  1  pipeline clock enable; low freezes every register
coeff_valid  in  1  coeff_in/addr_in valid this enabled cycle
coeff_in  in  12  QF, signed two's complement
addr_in  in  6  raster position u_v (row*8+col), already inverse-scanned
coeff_last  in  1  64th coefficient of block; addr_in is 63 whenever set
intra  in  1  macroblock_intra, held constant per block
intra_dc_precision  in  2  0..3
q_scale_type  in  1  0 linear, 1 non-linear
quantiser_scale_code  in  5  1..31
quant_rd_addr  out  6  matrix read address
quant_rd_clk_en  out  1  equals clk_en (combinational)
intra_quant_in  in  8  W from intra matrix
non_intra_quant_in  in  8  W from non-intra matrix
coeff_out  out  12  F, signed
coeff_out_valid  out  1  coeff_out valid
coeff_out_last  out  1  last coefficient of block

Behaviour:
- Reset (rst low at posedge): all pipeline registers 0, quant_rd_addr 0, coeff_out 0, coeff_out_valid 0, coeff_out_last 0, mismatch parity 0.
- Reset mid-block discards the partial block; the next block starts with parity 0.
- clk_en low: no register changes, outputs hold, no coefficient accepted. Latency counts enabled cycles only.
- Pipeline, input sampled at enabled edge t:
  - S1 (edge t): register QF, addr, flags, scale, dc_precision; quant_rd_addr <= addr_in.
  - Matrices return W at their outputs after edge t+2; a 2-enabled-cycle read latency is guaranteed because quant_rd_clk_en = clk_en.
  - S2 (t+1): delay only.
  - S3 (t+2): select W by delayed intra; form the product.
  - S4 (t+3): divide and saturate.
  - S5 (t+4): mismatch; outputs register.
  - coeff_out_valid therefore rises after enabled edge t+4 (5 enabled cycles). Throughput is 1 coefficient per enabled cycle, with no bubbles needed between blocks.
- quantiser_scale:
  - q_scale_type 0: 2*code.
  - q_scale_type 1: table 1,2,3,4,5,6,7,8,10,12,14,16,18,20,22,24,28,32,36,40,44,48,52,56,64,72,80,88,96,104,112 for codes 1..31.
  - Code 0 yields scale 0, so F=0 before mismatch.
- Intra DC (intra=1, addr=0): F'' = QF*intra_dc_mult, with mult 8/4/2/1 for precision 0/1/2/3. W and scale are ignored.
- All other coefficients:
  - F'' = ((2*QF + k) * W * scale) / 32.
  - k=0 for intra; k=sign(QF) (-1, 0, +1) for non-intra.
  - QF=0 gives F''=0 for both intra and non-intra.
  - Product width is 29 bits signed.
  - Division truncates toward zero: add 31 before an arithmetic shift right by 5 when the product is negative.
- Saturation: F' clamped to [-2048, 2047].
- Mismatch:
  - Parity = XOR of LSBs of all F' in the block, including the last.
  - On coeff_last: if parity is 0 (sum even), toggle the LSB of the last F'; otherwise pass unchanged.
  - Parity clears after the last coefficient is output.
- Invalid input cycles propagate as bubbles (valid=0). They do not affect parity; coeff_out holds its previous value.

Test Plan:
1. intra=1, precision 0, QF=128 at addr 0 -> coeff_out=1024 exactly 5 enabled cycles later, valid=1.
2. intra=1, addr 1, W=16, q_scale_type 0, code 4, QF=3 -> 24. Non-intra with W=16, same scale: QF=1 -> 12; QF=-3 -> -28.
3. Truncation: non-intra, W=17, linear code 1, QF=-1 -> -3 (not -4); QF=1 -> 3.
4. Saturation: intra, addr 5, W=83, non-linear code 31, QF=2047 -> 2047; QF=-2048 -> -2048.
5. Mismatch, first block: intra block with DC QF=128 (F=1024), 62 zeros, last addr 63 QF=0 -> last out=1, coeff_out_last=1. Second block, back-to-back: DC F=1024 plus addr 1 -> 24 (as scenario 2), QF=0 elsewhere, parity even -> last out=1. Then non-intra block where addr 1 -> 12 and another coefficient -> 3, parity odd -> last out=0.
6. Stall and reset: toggle clk_en 0/1 randomly mid-block -> outputs identical to the unstalled run, shifted only by disabled cycles. Assert rst at coefficient 30 -> all outputs 0; the next block's mismatch matches a fresh block.

Source files
------------

// File: rtl/inverse_quantiser.sv
// Inverse quantiser: weighting, quantiser_scale, saturation and mismatch control.
// Matrix W arrives two enabled cycles after o_quant_rd_addr is registered.
module inverse_quantiser (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clk_en,
  input  logic        i_coeff_valid,
  input  logic [11:0] i_coeff_in,
  input  logic [5:0]  i_addr_in,
  input  logic        i_coeff_last,
  input  logic        i_intra,
  input  logic [1:0]  i_intra_dc_precision,
  input  logic        i_q_scale_type,
  input  logic [4:0]  i_quantiser_scale_code,
  output logic [5:0]  o_quant_rd_addr,
  output logic        o_quant_rd_clk_en,
  input  logic [7:0]  i_intra_quant_in,
  input  logic [7:0]  i_non_intra_quant_in,
  output logic [11:0] o_coeff_out,
  output logic        o_coeff_out_valid,
  output logic        o_coeff_out_last
);

  logic               r1_valid, r2_valid, r3_valid, r4_valid;
  logic               r1_last, r2_last, r3_last, r4_last;
  logic               r1_intra, r2_intra, r3_intra;
  logic               r1_dc, r2_dc, r3_dc;
  logic [11:0]        r1_qf, r2_qf, r3_qf;
  logic signed [13:0] r1_term, r2_term, r3_term;
  logic [6:0]         r1_scale, r2_scale, r3_scale;
  logic [1:0]         r1_prec, r2_prec, r3_prec;
  logic signed [28:0] r4_prod;
  logic               r_parity;

  logic [6:0]         w_scale;
  logic signed [13:0] w_qf14, w_k, w_term;
  logic [7:0]         w_w;
  logic signed [28:0] w_qf_ext, w_term_ext, w_w_ext, w_scale_ext;
  logic signed [28:0] w_dc_prod, w_prod, w_adj, w_div;
  logic [11:0]        w_sat, w_f;
  logic               w_par;

  assign o_quant_rd_clk_en = i_clk_en;

  always_comb begin
    w_scale = {1'b0, i_quantiser_scale_code, 1'b0};
    if (i_q_scale_type) begin
      case (i_quantiser_scale_code)
        5'd0:  w_scale = 7'd0;
        5'd1:  w_scale = 7'd1;
        5'd2:  w_scale = 7'd2;
        5'd3:  w_scale = 7'd3;
        5'd4:  w_scale = 7'd4;
        5'd5:  w_scale = 7'd5;
        5'd6:  w_scale = 7'd6;
        5'd7:  w_scale = 7'd7;
        5'd8:  w_scale = 7'd8;
        5'd9:  w_scale = 7'd10;
        5'd10: w_scale = 7'd12;
        5'd11: w_scale = 7'd14;
        5'd12: w_scale = 7'd16;
        5'd13: w_scale = 7'd18;
        5'd14: w_scale = 7'd20;
        5'd15: w_scale = 7'd22;
        5'd16: w_scale = 7'd24;
        5'd17: w_scale = 7'd28;
        5'd18: w_scale = 7'd32;
        5'd19: w_scale = 7'd36;
        5'd20: w_scale = 7'd40;
        5'd21: w_scale = 7'd44;
        5'd22: w_scale = 7'd48;
        5'd23: w_scale = 7'd52;
        5'd24: w_scale = 7'd56;
        5'd25: w_scale = 7'd64;
        5'd26: w_scale = 7'd72;
        5'd27: w_scale = 7'd80;
        5'd28: w_scale = 7'd88;
        5'd29: w_scale = 7'd96;
        5'd30: w_scale = 7'd104;
        default: w_scale = 7'd112;
      endcase
    end
  end

  // 2*QF + k needs 14 bits: -2048 non-intra gives -4097
  always_comb begin
    w_qf14 = {{2{i_coeff_in[11]}}, i_coeff_in};
    w_k    = 14'sd0;
    if (!i_intra && (i_coeff_in != 12'd0))
      w_k = i_coeff_in[11] ? -14'sd1 : 14'sd1;
    w_term = (w_qf14 <<< 1) + w_k;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r1_valid <= 1'b0; r2_valid <= 1'b0; r3_valid <= 1'b0; r4_valid <= 1'b0;
      r1_last  <= 1'b0; r2_last  <= 1'b0; r3_last  <= 1'b0; r4_last  <= 1'b0;
      r1_intra <= 1'b0; r2_intra <= 1'b0; r3_intra <= 1'b0;
      r1_dc    <= 1'b0; r2_dc    <= 1'b0; r3_dc    <= 1'b0;
      r1_qf    <= '0;   r2_qf    <= '0;   r3_qf    <= '0;
      r1_term  <= '0;   r2_term  <= '0;   r3_term  <= '0;
      r1_scale <= '0;   r2_scale <= '0;   r3_scale <= '0;
      r1_prec  <= '0;   r2_prec  <= '0;   r3_prec  <= '0;
      r4_prod  <= '0;
      o_quant_rd_addr <= '0;
    end else if (i_clk_en) begin
      r1_valid <= i_coeff_valid;
      r1_last  <= i_coeff_valid & i_coeff_last;
      r1_intra <= i_intra;
      r1_dc    <= i_intra && (i_addr_in == 6'd0);
      r1_qf    <= i_coeff_in;
      r1_term  <= w_term;
      r1_scale <= w_scale;
      r1_prec  <= i_intra_dc_precision;
      o_quant_rd_addr <= i_addr_in;

      r2_valid <= r1_valid; r2_last <= r1_last; r2_intra <= r1_intra; r2_dc <= r1_dc;
      r2_qf    <= r1_qf;    r2_term <= r1_term; r2_scale <= r1_scale; r2_prec <= r1_prec;

      r3_valid <= r2_valid; r3_last <= r2_last; r3_intra <= r2_intra; r3_dc <= r2_dc;
      r3_qf    <= r2_qf;    r3_term <= r2_term; r3_scale <= r2_scale; r3_prec <= r2_prec;

      r4_valid <= r3_valid;
      r4_last  <= r3_last;
      r4_prod  <= w_prod;
    end
  end

  // DC is pre-scaled by 32 so the shared divide below is exact for it
  always_comb begin
    w_w         = r3_intra ? i_intra_quant_in : i_non_intra_quant_in;
    w_qf_ext    = {{17{r3_qf[11]}}, r3_qf};
    w_term_ext  = {{15{r3_term[13]}}, r3_term};
    w_w_ext     = {21'd0, w_w};
    w_scale_ext = {22'd0, r3_scale};
    w_dc_prod   = w_qf_ext <<< (4'd8 - {2'b00, r3_prec});
    w_prod      = r3_dc ? w_dc_prod : (w_term_ext * w_w_ext * w_scale_ext);
  end

  always_comb begin
    w_adj = r4_prod + (r4_prod[28] ? 29'sd31 : 29'sd0);
    w_div = w_adj >>> 5;
    if (w_div > 29'sd2047)
      w_sat = 12'h7FF;
    else if (w_div < -29'sd2048)
      w_sat = 12'h800;
    else
      w_sat = w_div[11:0];
    w_par = r_parity ^ w_sat[0];
    w_f   = w_sat;
    if (r4_last && !w_par)
      w_f[0] = ~w_sat[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_coeff_out       <= '0;
      o_coeff_out_valid <= 1'b0;
      o_coeff_out_last  <= 1'b0;
      r_parity          <= 1'b0;
    end else if (i_clk_en) begin
      o_coeff_out_valid <= r4_valid;
      o_coeff_out_last  <= r4_valid & r4_last;
      if (r4_valid) begin
        o_coeff_out <= w_f;
        r_parity    <= r4_last ? 1'b0 : w_par;
      end
    end
  end

endmodule
